// File: rtl/seg7_display_sequencer_if.sv
// Client request/grant and display-controller write bus shared by the
// sequencer (master side) and its environment (slave side).
interface seg7_display_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_value;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic                          o_bus_wr;
    logic [ADDR_WIDTH-1:0]         o_bus_addr;
    logic [DATA_WIDTH-1:0]         o_bus_wdata;
    logic                          i_bus_ack;
    logic                          o_busy;

    modport master (
        input  i_req_valid, i_req_value, i_bus_ack,
        output o_req_ready, o_bus_wr, o_bus_addr, o_bus_wdata, o_busy
    );

    modport slave (
        output i_req_valid, i_req_value, i_bus_ack,
        input  o_req_ready, o_bus_wr, o_bus_addr, o_bus_wdata, o_busy
    );
endinterface

// File: rtl/seg7_display_sequencer.sv
// Round-robin arbiter over display clients feeding a digit-by-digit writer
// for the 7-segment controller, with optional periodic rewrite of the last value.
module seg7_display_sequencer #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [63:0] BASE_ADDR      = 64'hc000_1000,
    parameter int          NUM_7SEGMENTS  = 8,
    parameter int          NUM_REQ        = 2,
    parameter int          REFRESH_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    seg7_display_sequencer_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = (NUM_7SEGMENTS > 1) ? $clog2(NUM_7SEGMENTS) : 1;
    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [PTR_W-1:0] PTR_RESET    = PTR_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_7SEGMENTS - 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam logic             REFRESH_EN   = (REFRESH_CYCLES > 0);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        last_grant_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_W-1:0]        refresh_cnt_q;
    logic                    have_value_q;
    logic [DATA_WIDTH-1:0]   value_q;

    logic                    grant_any;
    logic [PTR_W-1:0]        grant_idx;
    logic [NUM_REQ-1:0]      grant_oh;
    logic [DATA_WIDTH-1:0]   grant_value;
    logic                    accept;
    logic                    refresh_fire;
    logic                    last_ack;
    logic [3:0]              nibble;

    // Clients after last_grant are searched first, then the wrap-around half,
    // which yields the first valid client at or after last_grant+1.
    always_comb begin
        grant_any   = 1'b0;
        grant_idx   = last_grant_q;
        grant_oh    = '0;
        grant_value = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && bus.i_req_valid[j] && (j > int'(last_grant_q))) begin
                grant_any   = 1'b1;
                grant_idx   = PTR_W'(j);
                grant_oh[j] = 1'b1;
                grant_value = bus.i_req_value[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && bus.i_req_valid[j] && (j <= int'(last_grant_q))) begin
                grant_any   = 1'b1;
                grant_idx   = PTR_W'(j);
                grant_oh[j] = 1'b1;
                grant_value = bus.i_req_value[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept       = (state_q == IDLE) && !rst && grant_any;
    // Any pending request suppresses the refresh so the request always wins.
    assign refresh_fire = REFRESH_EN && have_value_q && (refresh_cnt_q == REFRESH_LAST)
                          && !(|bus.i_req_valid);
    assign last_ack     = bus.i_bus_ack && (idx_q == LAST_IDX);
    assign nibble       = 4'(value_q >> {idx_q, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.o_req_ready = '0;
        bus.o_bus_wr    = 1'b0;
        bus.o_busy      = 1'b0;
        bus.o_bus_addr  = '0;
        bus.o_bus_wdata = '0;
        unique case (state_q)
            IDLE: begin
                bus.o_req_ready = accept ? grant_oh : '0;
                if (accept || refresh_fire) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                bus.o_bus_wr    = 1'b1;
                bus.o_busy      = 1'b1;
                bus.o_bus_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({idx_q, 2'b00});
                bus.o_bus_wdata = DATA_WIDTH'(nibble);
                if (last_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: arbitration pointer, digit index, refresh timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q  <= PTR_RESET;
            idx_q         <= '0;
            refresh_cnt_q <= '0;
            have_value_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    if (accept) begin
                        last_grant_q  <= grant_idx;
                        have_value_q  <= 1'b1;
                        refresh_cnt_q <= '0;
                    end else if (refresh_fire) begin
                        refresh_cnt_q <= '0;
                    end else if (REFRESH_EN && have_value_q) begin
                        refresh_cnt_q <= refresh_cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    refresh_cnt_q <= '0;
                    if (bus.i_bus_ack) begin
                        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    end
                end
                default: idx_q <= '0;
            endcase
        end
    end

    // The value only changes on a grant, so a busy sequence keeps its data.
    always_ff @(posedge clk) begin
        if (accept) begin
            value_q <= grant_value;
        end
    end
endmodule

// File: tb/tb_seg7_display_sequencer.sv
// Scoreboard bench for seg7_display_sequencer: grants and digit writes are
// predicted from the driven client values and compared as the DUT emits them.
module tb_seg7_display_sequencer;
    localparam int          ADDR_WIDTH = 32;
    localparam int          DATA_WIDTH = 32;
    localparam int          NUM_SEG    = 8;
    localparam int          NUM_REQ    = 2;
    localparam int          REFRESH    = 10;
    localparam logic [31:0] BASE       = 32'hc000_1000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_display_sequencer_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                                .NUM_REQ(NUM_REQ)) bus ();

    seg7_display_sequencer #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BASE_ADDR(64'hc000_1000),
        .NUM_7SEGMENTS(NUM_SEG), .NUM_REQ(NUM_REQ), .REFRESH_CYCLES(REFRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    wr_t                wq[$];
    logic [NUM_REQ-1:0] gq[$];
    logic [31:0]        cval [NUM_REQ];
    int checks = 0, errors = 0;
    int cyc = 0, wr_cycles = 0, acks = 0, grants = 0;
    int grant_cyc = 0, idle_cyc = 0;
    bit grant_pending = 0, wr_prev = 0;
    int ack_delay = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_update(input logic [31:0] v);
        for (int k = 0; k < NUM_SEG; k++)
            wq.push_back(wr_t'{addr: BASE + 32'(4*k), data: (v >> (4*k)) & 32'hF});
    endtask

    task automatic set_client(input int j, input logic [31:0] v);
        cval[j] = v;
        bus.i_req_value[j*DATA_WIDTH +: DATA_WIDTH] = v;
    endtask

    always @(posedge clk) cyc++;

    // Acknowledge each write after ack_delay wait cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.i_bus_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || !bus.o_bus_wr) begin
                wcnt = 0;
                bus.i_bus_ack = 1'b0;
            end else begin
                bus.i_bus_ack = (wcnt >= ack_delay);
                wcnt = bus.i_bus_ack ? 0 : wcnt + 1;
            end
        end
    end

    // Monitor: grants push their predicted writes; writes are checked against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            wr_prev = 0;
            grant_pending = 0;
        end else begin
            if (|bus.o_req_ready) begin
                grants++;
                if (gq.size() == 0) check_eq("grant_unexpected", bus.o_req_ready, 0);
                else check_eq("grant_onehot", bus.o_req_ready, gq.pop_front());
                check_eq("grant_while_writes_pending", wq.size(), 0);
                for (int j = 0; j < NUM_REQ; j++)
                    if (bus.o_req_ready[j]) push_update(cval[j]);
                grant_cyc = cyc;
                grant_pending = 1;
            end
            if (bus.o_bus_wr) begin
                wr_cycles++;
                if (!wr_prev) begin
                    if (grant_pending) check_eq("first_write_latency", cyc - grant_cyc, 1);
                    else check_eq("refresh_latency", cyc - idle_cyc, REFRESH);
                    grant_pending = 0;
                end
                check_eq("busy_during_write", bus.o_busy, 1);
                if (wq.size() == 0) begin
                    check_eq("write_queue_depth", 0, 1);
                end else begin
                    check_eq("wr_addr", bus.o_bus_addr, wq[0].addr);
                    check_eq("wr_data", bus.o_bus_wdata, wq[0].data);
                    if (bus.i_bus_ack) begin
                        void'(wq.pop_front());
                        acks++;
                    end
                end
            end else if (wr_prev) begin
                idle_cyc = cyc;
                check_eq("busy_after_sequence", bus.o_busy, 0);
            end
            wr_prev = bus.o_bus_wr;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.i_req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("queue_empty_at_reset", wq.size() + gq.size(), 0);
        wq.delete();
        gq.delete();
        rst = 1'b0;
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int i = 0; i < budget && grants < n; i++) begin
            @(posedge clk); #1;
        end
        if (grants < n) check_eq("grant_timeout", grants, n);
    endtask

    task automatic wait_seq_done(input int budget);
        int i;
        for (i = 0; i < budget && !bus.o_busy; i++) begin
            @(posedge clk); #1;
        end
        if (!bus.o_busy) check_eq("busy_rise_timeout", bus.o_busy, 1);
        for (i = 0; i < budget && bus.o_busy; i++) begin
            @(posedge clk); #1;
        end
        if (bus.o_busy) check_eq("busy_fall_timeout", bus.o_busy, 0);
    endtask

    initial begin
        int base_wr, base_ack;
        bus.i_req_valid = '0;
        bus.i_req_value = '0;
        cval[0] = '0;
        cval[1] = '0;

        // Reset state, with requests present to show ready is gated by rst.
        rst = 1'b1;
        bus.i_req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", bus.o_req_ready, 0);
        check_eq("rst_wr", bus.o_bus_wr, 0);
        check_eq("rst_addr", bus.o_bus_addr, 0);
        check_eq("rst_wdata", bus.o_bus_wdata, 0);
        check_eq("rst_busy", bus.o_busy, 0);
        bus.i_req_valid = '0;
        rst = 1'b0;

        // No stored value: refresh must stay silent.
        base_wr = wr_cycles;
        repeat (3 * REFRESH) @(posedge clk);
        #1;
        check_eq("no_value_no_refresh", wr_cycles - base_wr, 0);

        // Single update, zero-wait ack.
        do_reset();
        set_client(0, 32'h1234_5678);
        gq.push_back(2'b01);
        base_wr = wr_cycles;
        bus.i_req_valid = 2'b01;
        wait_grants(grants + 1, 20);
        bus.i_req_valid = '0;
        wait_seq_done(40);
        check_eq("single_wr_cycles", wr_cycles - base_wr, NUM_SEG);
        check_eq("single_queue_drained", wq.size(), 0);

        // Two clients held valid: grants alternate starting at client 0.
        do_reset();
        set_client(0, 32'hAAAA_AAAA);
        set_client(1, 32'h5555_5555);
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
        bus.i_req_valid = 2'b11;
        wait_grants(grants + 4, 100);
        bus.i_req_valid = '0;
        wait_seq_done(40);
        check_eq("rr_grants_consumed", gq.size(), 0);
        check_eq("rr_queue_drained", wq.size(), 0);

        // Three wait cycles per write.
        do_reset();
        ack_delay = 3;
        set_client(0, 32'h0000_00F3);
        gq.push_back(2'b01);
        base_wr = wr_cycles;
        bus.i_req_valid = 2'b01;
        wait_grants(grants + 1, 20);
        bus.i_req_valid = '0;
        wait_seq_done(100);
        check_eq("slow_wr_cycles", wr_cycles - base_wr, 4 * NUM_SEG);
        ack_delay = 0;

        // Refresh rewrites the stored value twice.
        do_reset();
        set_client(0, 32'hDEAD_BEEF);
        gq.push_back(2'b01);
        bus.i_req_valid = 2'b01;
        wait_grants(grants + 1, 20);
        bus.i_req_valid = '0;
        wait_seq_done(40);
        for (int r = 0; r < 2; r++) begin
            push_update(32'hDEAD_BEEF);
            wait_seq_done(40);
        end
        check_eq("refresh_queue_drained", wq.size(), 0);

        // A request landing on the refresh-expiry cycle wins.
        do_reset();
        set_client(0, 32'h0BAD_F00D);
        gq.push_back(2'b01);
        bus.i_req_valid = 2'b01;
        wait_grants(grants + 1, 20);
        bus.i_req_valid = '0;
        wait_seq_done(40);
        repeat (REFRESH - 1) @(posedge clk);
        #1;
        set_client(1, 32'h1357_9BDF);
        gq.push_back(2'b10);
        bus.i_req_valid = 2'b10;
        wait_grants(grants + 1, 5);
        check_eq("coincide_grant_cycle", grant_cyc - idle_cyc, REFRESH - 1);
        bus.i_req_valid = '0;
        wait_seq_done(40);
        check_eq("coincide_queue_drained", wq.size(), 0);

        // Reset after the third ack aborts the sequence.
        do_reset();
        set_client(0, 32'h8765_4321);
        gq.push_back(2'b01);
        bus.i_req_valid = 2'b01;
        wait_grants(grants + 1, 20);
        bus.i_req_valid = '0;
        base_ack = acks;
        for (int i = 0; i < 20 && acks < base_ack + 3; i++) begin
            @(posedge clk); #1;
        end
        check_eq("abort_acks_before_rst", acks - base_ack, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_wr_after_rst", bus.o_bus_wr, 0);
        check_eq("abort_remaining", wq.size(), NUM_SEG - 3);
        wq.delete();
        base_wr = wr_cycles;
        repeat (5) @(posedge clk);
        #1;
        check_eq("abort_no_more_writes", wr_cycles - base_wr, 0);
        set_client(0, 32'hCAFE_0001);
        set_client(1, 32'hCAFE_0002);
        gq.push_back(2'b01);
        bus.i_req_valid = 2'b11;
        wait_grants(grants + 1, 20);
        bus.i_req_valid = '0;
        wait_seq_done(40);
        check_eq("post_abort_queue_drained", wq.size(), 0);

        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_display_sequencer.md
Name: seg7_display_sequencer

Overview:
- Bus master that sequences the 7-segment display controller slave.
- Arbitrates round-robin among NUM_REQ display clients, each presenting a DATA_WIDTH value.
- Latches the granted value and issues one register write per digit (nibble k to BASE_ADDR + 4*k).
- Optionally rewrites the last value periodically so the display recovers from stray writes.

Parameters:
ADDR_WIDTH, 32, bus address width
DATA_WIDTH, 32, bus data width and client value width
BASE_ADDR, 32'hc0001000, base address of the 7-segment controller's digit registers
NUM_7SEGMENTS, 8, number of digits written per update; must satisfy 4*NUM_7SEGMENTS <= DATA_WIDTH
NUM_REQ, 2, number of requesting clients, >= 1
REFRESH_CYCLES, 0, idle cycles before the last value is rewritten; 0 disables refresh

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
i_req_valid  input  NUM_REQ  per-client update request
i_req_value  input  NUM_REQ*DATA_WIDTH  flattened client values; client j occupies bits [j*DATA_WIDTH +: DATA_WIDTH]
o_req_ready  output  NUM_REQ  one-hot grant; the value is accepted on the cycle valid & ready
o_bus_wr  output  1  write request to the display controller
o_bus_addr  output  ADDR_WIDTH  write address
o_bus_wdata  output  DATA_WIDTH  write data, zero-extended nibble
i_bus_ack  input  1  write accepted this cycle
o_busy  output  1  high while a write sequence is in progress

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset state: state IDLE. o_bus_wr=0, o_bus_addr=0, o_bus_wdata=0, o_busy=0, o_req_ready=0.
- Reset also clears the round-robin pointer (client 0 has highest priority), the digit index, the refresh counter and the have_value flag.
- States are IDLE and WRITE.
- Arbitration in IDLE:
  - o_req_ready is combinational, one-hot, and asserted only in IDLE while rst=0.
  - Grant goes to the first valid client at or after (last_grant+1) mod NUM_REQ.
  - On grant: capture the value, set have_value=1, update last_grant, go to WRITE next cycle.
  - o_req_ready=0 in WRITE; clients hold valid until granted.
- Refresh:
  - In IDLE with REFRESH_CYCLES>0 and have_value=1, a counter increments each cycle.
  - When it reaches REFRESH_CYCLES-1 and no i_req_valid is set, go to WRITE with the stored value unchanged.
  - The counter clears on every entry to IDLE and on any grant.
  - If a request and a refresh coincide, the request wins.
  - have_value=0 means no refresh occurs.
- WRITE:
  - o_bus_wr=1, o_busy=1, o_bus_addr = BASE_ADDR + 4*idx (mod 2^ADDR_WIDTH), o_bus_wdata = {zeros, value[4*idx+3:4*idx]}.
  - idx starts at 0, so the least-significant digit is written first.
  - Addr and data stay stable while i_bus_ack=0. There is no timeout; the block waits indefinitely.
  - On the cycle i_bus_ack=1:
    - If idx < NUM_7SEGMENTS-1: idx++, and o_bus_wr stays high with the new addr/data on the next cycle (back-to-back writes, no idle cycle).
    - If idx = NUM_7SEGMENTS-1: next cycle IDLE with o_bus_wr=0, o_busy=0, idx=0.
  - i_bus_ack outside WRITE is ignored.
- Latency: grant at cycle T, first o_bus_wr at T+1. With zero-wait ack, a full update takes NUM_7SEGMENTS cycles of o_bus_wr, and the earliest next grant is T+1+NUM_7SEGMENTS.
- A new request during WRITE does not alter the in-flight sequence; the value is not overwritten mid-sequence.
- Reset mid-sequence aborts the sequence: o_bus_wr=0 on the cycle after rst is sampled, and no further writes occur for the aborted value.
- NUM_REQ=1: the arbiter degenerates to a pass-through grant.

Test Plan:
- Reset, then client 0 valid with 32'h1234_5678 and zero-wait ack -> ready[0] pulses one cycle; 8 writes on consecutive cycles to 0xc0001000..0xc000101c with data 8,7,6,5,4,3,2,1; then o_busy=0.
- Clients 0 and 1 both valid continuously (32'hAAAA_AAAA, 32'h5555_5555) -> grants alternate 0,1,0,1 starting with client 0; each sequence completes before the next grant.
- i_bus_ack delayed 3 cycles per write on value 32'h0000_00F3 -> digit 0 addr/data (0xc0001000, 3) held stable for 4 cycles, next write is digit 1 with data 0xF; total of 32 cycles of o_bus_wr.
- REFRESH_CYCLES=10, one update of 32'hDEAD_BEEF, then no requests -> identical 8-write sequence repeats 10 cycles after each return to IDLE; with no prior value after reset, no writes occur.
- Request arrives on the same cycle the refresh counter expires -> request is granted and its new value is written, not the stale one.
- rst asserted after the 3rd ack of a sequence -> o_bus_wr=0 the next cycle, no further writes; after release, the next request starts at digit 0 with client 0 priority.
